// File: rtl/rvm_fu_sequencer.sv
// Execute-stage sequencer: issues one decoded operation to one of NUM_FU units,
// waits for its valid (bounded by a watchdog) and writes the result to rd or PC.
module rvm_fu_sequencer #(
  parameter int XLEN    = 32,
  parameter int NUM_FU  = 3,
  parameter int FUSEL_W = 2,
  parameter int OPW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [FUSEL_W-1:0]         i_fu,
  input  logic [OPW-1:0]             i_op,
  input  logic [XLEN-1:0]            i_lhs,
  input  logic [XLEN-1:0]            i_rhs,
  input  logic [4:0]                 i_rd,
  input  logic                       i_pc_upd,
  output logic [NUM_FU-1:0]          fu_req,
  output logic [XLEN-1:0]            fu_lhs,
  output logic [XLEN-1:0]            fu_rhs,
  output logic [OPW-1:0]             fu_op,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*(XLEN+1)-1:0] fu_result,
  output logic                       d_rd_wen,
  output logic [4:0]                 d_rd_addr,
  output logic [XLEN-1:0]            d_rd_wdata,
  output logic                       d_pc_wen,
  output logic [XLEN-1:0]            d_pc_wdata,
  output logic                       o_done,
  output logic                       o_error,
  output logic                       o_carry
);

  localparam int                   CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [FUSEL_W:0]     FU_LIMIT = (FUSEL_W + 1)'(NUM_FU);

  typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

  state_t              state;
  logic [FUSEL_W-1:0]  sel_q;
  logic [OPW-1:0]      op_q;
  logic [XLEN-1:0]     lhs_q;
  logic [XLEN-1:0]     rhs_q;
  logic [4:0]          rd_q;
  logic                pc_upd_q;
  logic [CNT_W-1:0]    cnt;

  logic [NUM_FU-1:0]   issue_req;
  logic                sel_vld;
  logic [XLEN:0]       sel_res;

  // Decode the incoming selector and mux the latched unit's valid/result;
  // other units' outputs never reach the state machine.
  always_comb begin
    issue_req = '0;
    sel_vld   = 1'b0;
    sel_res   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (i_fu == FUSEL_W'(k)) issue_req[k] = 1'b1;
      if (sel_q == FUSEL_W'(k)) begin
        sel_vld = fu_valid[k];
        sel_res = fu_result[k*(XLEN+1) +: XLEN+1];
      end
    end
  end

  assign fu_lhs = lhs_q;
  assign fu_rhs = rhs_q;
  assign fu_op  = op_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      i_ready    <= 1'b1;
      fu_req     <= '0;
      d_rd_wen   <= 1'b0;
      d_rd_addr  <= '0;
      d_rd_wdata <= '0;
      d_pc_wen   <= 1'b0;
      d_pc_wdata <= '0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      o_carry    <= 1'b0;
      sel_q      <= '0;
      op_q       <= '0;
      lhs_q      <= '0;
      rhs_q      <= '0;
      rd_q       <= '0;
      pc_upd_q   <= 1'b0;
      cnt        <= '0;
    end else begin
      // Write-back and completion strobes are single-cycle by default.
      d_rd_wen   <= 1'b0;
      d_rd_addr  <= '0;
      d_rd_wdata <= '0;
      d_pc_wen   <= 1'b0;
      d_pc_wdata <= '0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            sel_q    <= i_fu;
            op_q     <= i_op;
            lhs_q    <= i_lhs;
            rhs_q    <= i_rhs;
            rd_q     <= i_rd;
            pc_upd_q <= i_pc_upd;
            i_ready  <= 1'b0;
            if ({1'b0, i_fu} >= FU_LIMIT) begin
              state   <= ERR;
              o_done  <= 1'b1;
              o_error <= 1'b1;
            end else begin
              state  <= EXEC;
              cnt    <= '0;
              fu_req <= issue_req;
            end
          end
        end
        EXEC: begin
          if (sel_vld) begin
            state   <= WB;
            fu_req  <= '0;
            o_done  <= 1'b1;
            o_carry <= sel_res[XLEN];
            if (pc_upd_q) begin
              d_pc_wen   <= 1'b1;
              d_pc_wdata <= sel_res[XLEN-1:0];
            end else if (rd_q != 5'd0) begin
              d_rd_wen   <= 1'b1;
              d_rd_addr  <= rd_q;
              d_rd_wdata <= sel_res[XLEN-1:0];
            end
          end else if (cnt == CNT_LAST) begin
            state   <= ERR;
            fu_req  <= '0;
            o_done  <= 1'b1;
            o_error <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB, ERR: begin
          state   <= IDLE;
          i_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          i_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvm_fu_sequencer.sv
// Bench for rvm_fu_sequencer: expected completions are queued at issue time and
// compared by a negedge monitor whenever the sequencer pulses o_done.
module tb_rvm_fu_sequencer;

  localparam int XLEN    = 32;
  localparam int NUM_FU  = 3;
  localparam int FUSEL_W = 2;
  localparam int OPW     = 2;
  localparam int TIMEOUT = 16;
  localparam int RW      = XLEN + 1;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b0;
  logic                   i_valid = 1'b0;
  logic                   i_ready;
  logic [FUSEL_W-1:0]     i_fu = '0;
  logic [OPW-1:0]         i_op = '0;
  logic [XLEN-1:0]        i_lhs = '0;
  logic [XLEN-1:0]        i_rhs = '0;
  logic [4:0]             i_rd = '0;
  logic                   i_pc_upd = 1'b0;
  logic [NUM_FU-1:0]      fu_req;
  logic [XLEN-1:0]        fu_lhs;
  logic [XLEN-1:0]        fu_rhs;
  logic [OPW-1:0]         fu_op;
  logic [NUM_FU-1:0]      fu_valid = '0;
  logic [NUM_FU*RW-1:0]   fu_result = '0;
  logic                   d_rd_wen;
  logic [4:0]             d_rd_addr;
  logic [XLEN-1:0]        d_rd_wdata;
  logic                   d_pc_wen;
  logic [XLEN-1:0]        d_pc_wdata;
  logic                   o_done;
  logic                   o_error;
  logic                   o_carry;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            rd_wen;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic            pc_wen;
    logic [XLEN-1:0] pc_wdata;
    logic            err;
  } exp_t;

  exp_t exp_q[$];

  rvm_fu_sequencer #(
    .XLEN(XLEN), .NUM_FU(NUM_FU), .FUSEL_W(FUSEL_W), .OPW(OPW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_fu(i_fu), .i_op(i_op),
    .i_lhs(i_lhs), .i_rhs(i_rhs), .i_rd(i_rd), .i_pc_upd(i_pc_upd),
    .fu_req(fu_req), .fu_lhs(fu_lhs), .fu_rhs(fu_rhs), .fu_op(fu_op),
    .fu_valid(fu_valid), .fu_result(fu_result),
    .d_rd_wen(d_rd_wen), .d_rd_addr(d_rd_addr), .d_rd_wdata(d_rd_wdata),
    .d_pc_wen(d_pc_wen), .d_pc_wdata(d_pc_wdata),
    .o_done(o_done), .o_error(o_error), .o_carry(o_carry)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: o_done=1 err=%0b rd_wen=%0b pc_wen=%0b, required no completion",
                 o_error, d_rd_wen, d_pc_wen);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (d_rd_wen !== e.rd_wen || d_rd_addr !== e.rd_addr || d_rd_wdata !== e.rd_wdata ||
            d_pc_wen !== e.pc_wen || d_pc_wdata !== e.pc_wdata || o_error !== e.err) begin
          errors++;
          $display("FAIL completion: got rd_wen=%0b addr=%0d rd=%h pc_wen=%0b pc=%h err=%0b, required rd_wen=%0b addr=%0d rd=%h pc_wen=%0b pc=%h err=%0b",
                   d_rd_wen, d_rd_addr, d_rd_wdata, d_pc_wen, d_pc_wdata, o_error,
                   e.rd_wen, e.rd_addr, e.rd_wdata, e.pc_wen, e.pc_wdata, e.err);
        end
      end
    end else if (d_rd_wen || d_pc_wen || o_error) begin
      checks++;
      errors++;
      $display("FAIL stray_strobe: rd_wen=%0b pc_wen=%0b err=%0b without o_done, required 0",
               d_rd_wen, d_pc_wen, o_error);
    end
  end

  function automatic exp_t mk_exp(logic rw, logic [4:0] a, logic [XLEN-1:0] rd,
                                  logic pw, logic [XLEN-1:0] pc, logic er);
    exp_t e;
    e.rd_wen = rw; e.rd_addr = a; e.rd_wdata = rd;
    e.pc_wen = pw; e.pc_wdata = pc; e.err = er;
    return e;
  endfunction

  // Waits (bounded) for i_ready, presents one issue and returns #1 after the accepting edge.
  task automatic issue(input logic [FUSEL_W-1:0] fu, input logic [OPW-1:0] op,
                       input logic [XLEN-1:0] lhs, input logic [XLEN-1:0] rhs,
                       input logic [4:0] rd, input logic pc);
    int waited = 0;
    while (i_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (i_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: i_ready=%0b after %0d cycles, required 1", i_ready, waited);
    end
    i_valid = 1'b1; i_fu = fu; i_op = op; i_lhs = lhs; i_rhs = rhs; i_rd = rd; i_pc_upd = pc;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (i_ready !== 1'b1 || fu_req !== '0 || o_done !== 1'b0 || o_error !== 1'b0 ||
        d_rd_wen !== 1'b0 || d_pc_wen !== 1'b0 || o_carry !== 1'b0 || fu_lhs !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%0b req=%b done=%0b err=%0b rdw=%0b pcw=%0b carry=%0b lhs=%h, required 1/000/0/0/0/0/0/0",
               i_ready, fu_req, o_done, o_error, d_rd_wen, d_pc_wen, o_carry, fu_lhs);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (i_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: i_ready=%0b, required 1", i_ready);
    end
  endtask

  task automatic test_add();
    issue(2'd0, 2'd1, 32'hFFFF_FFFF, 32'h1, 5'd5, 1'b0);
    checks++;
    if (fu_req !== 3'b001 || i_ready !== 1'b0 || fu_lhs !== 32'hFFFF_FFFF ||
        fu_rhs !== 32'h1 || fu_op !== 2'd1) begin
      errors++;
      $display("FAIL add_exec: req=%b ready=%0b lhs=%h rhs=%h op=%0d, required 001/0/ffffffff/00000001/1",
               fu_req, i_ready, fu_lhs, fu_rhs, fu_op);
    end
    exp_q.push_back(mk_exp(1'b1, 5'd5, 32'h0, 1'b0, 32'h0, 1'b0));
    fu_result = '0;
    fu_result[0*RW +: RW] = 33'h1_0000_0000;
    fu_valid = 3'b001;
    @(posedge clk); #1;  // N+2: write-back
    fu_valid = '0;
    checks++;
    if (o_done !== 1'b1 || o_carry !== 1'b1) begin
      errors++;
      $display("FAIL add_wb: done=%0b carry=%0b, required 1/1", o_done, o_carry);
    end
    @(posedge clk); #1;  // N+3
    checks++;
    if (i_ready !== 1'b1 || o_carry !== 1'b1 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL add_ready: ready=%0b carry=%0b done=%0b, required 1/1/0", i_ready, o_carry, o_done);
    end
  endtask

  task automatic test_timeout();
    issue(2'd1, 2'd2, 32'hA, 32'hB, 5'd3, 1'b0);
    exp_q.push_back(mk_exp(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1));
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;  // N+16: last EXEC cycle
    checks++;
    if (fu_req !== 3'b010 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_last_exec: req=%b done=%0b, required 010/0", fu_req, o_done);
    end
    @(posedge clk); #1;  // N+17: ERR
    checks++;
    if (o_done !== 1'b1 || o_error !== 1'b1 || fu_req !== '0 || o_carry !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err: done=%0b err=%0b req=%b carry=%0b, required 1/1/000/1",
               o_done, o_error, fu_req, o_carry);
    end
    @(posedge clk); #1;  // N+18
    checks++;
    if (i_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ready: i_ready=%0b, required 1", i_ready);
    end
  endtask

  task automatic test_delayed();
    issue(2'd2, 2'd3, 32'h5, 32'h6, 5'd7, 1'b0);
    exp_q.push_back(mk_exp(1'b1, 5'd7, 32'h10, 1'b0, 32'h0, 1'b0));
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (fu_req !== 3'b100 || fu_lhs !== 32'h5 || fu_op !== 2'd3) begin
        errors++;
        $display("FAIL delayed_req_c%0d: req=%b lhs=%h op=%0d, required 100/00000005/3", c, fu_req, fu_lhs, fu_op);
      end
      fu_result = '0;
      fu_valid  = '0;
      if (c == 2) begin
        fu_result[1*RW +: RW] = 33'h0_DEAD_BEEF;
        fu_valid = 3'b010;
      end
      if (c == 5) begin
        fu_result[2*RW +: RW] = 33'h0_0000_0010;
        fu_valid = 3'b100;
      end
      @(posedge clk); #1;
    end
    fu_valid = '0;
    checks++;
    if (o_done !== 1'b1 || o_carry !== 1'b0 || fu_req !== '0) begin
      errors++;
      $display("FAIL delayed_wb: done=%0b carry=%0b req=%b, required 1/0/000", o_done, o_carry, fu_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    issue(2'd3, 2'd0, 32'h1, 32'h2, 5'd4, 1'b0);
    exp_q.push_back(mk_exp(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1));
    checks++;
    if (o_error !== 1'b1 || o_done !== 1'b1 || fu_req !== '0) begin
      errors++;
      $display("FAIL illegal_err: err=%0b done=%0b req=%b, required 1/1/000", o_error, o_done, fu_req);
    end
    @(posedge clk); #1;
    checks++;
    if (fu_req !== '0 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_after: req=%b ready=%0b, required 000/1", fu_req, i_ready);
    end
  endtask

  task automatic test_x0();
    issue(2'd0, 2'd0, 32'h1, 32'h2, 5'd0, 1'b0);
    exp_q.push_back(mk_exp(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0));
    fu_result = '0;
    fu_result[0*RW +: RW] = 33'h1_0000_1234;
    fu_valid = 3'b001;
    @(posedge clk); #1;
    fu_valid = '0;
    checks++;
    if (o_done !== 1'b1 || d_rd_wen !== 1'b0 || o_carry !== 1'b1) begin
      errors++;
      $display("FAIL x0_wb: done=%0b rd_wen=%0b carry=%0b, required 1/0/1", o_done, d_rd_wen, o_carry);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pc_update();
    issue(2'd0, 2'd2, 32'h3FC, 32'h4, 5'd9, 1'b1);
    exp_q.push_back(mk_exp(1'b0, 5'd0, 32'h0, 1'b1, 32'h400, 1'b0));
    fu_result = '0;
    fu_result[0*RW +: RW] = 33'h0_0000_0400;
    fu_valid = 3'b001;
    @(posedge clk); #1;
    fu_valid = '0;
    checks++;
    if (d_pc_wen !== 1'b1 || d_pc_wdata !== 32'h400 || d_rd_wen !== 1'b0 || o_carry !== 1'b0) begin
      errors++;
      $display("FAIL pc_wb: pc_wen=%0b pc=%h rd_wen=%0b carry=%0b, required 1/00000400/0/0",
               d_pc_wen, d_pc_wdata, d_rd_wen, o_carry);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    // i_valid stays high while busy: only the first request may be taken.
    issue(2'd1, 2'd1, 32'h11, 32'h22, 5'd12, 1'b0);
    exp_q.push_back(mk_exp(1'b1, 5'd12, 32'hCAFE_0001, 1'b0, 32'h0, 1'b0));
    i_valid = 1'b1; i_fu = 2'd2; i_rd = 5'd13; i_lhs = 32'h33;
    fu_result = '0;
    fu_result[1*RW +: RW] = 33'h0_CAFE_0001;
    fu_valid = 3'b010;
    @(posedge clk); #1;  // WB of first op, second request still pending
    fu_valid = '0;
    checks++;
    if (fu_lhs !== 32'h11 || i_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: lhs=%h ready=%0b, required 00000011/0", fu_lhs, i_ready);
    end
    @(posedge clk); #1;  // IDLE: second request accepted at the next edge
    @(posedge clk); #1;
    i_valid = 1'b0;
    exp_q.push_back(mk_exp(1'b1, 5'd13, 32'h0000_0077, 1'b0, 32'h0, 1'b0));
    checks++;
    if (fu_req !== 3'b100 || fu_lhs !== 32'h33) begin
      errors++;
      $display("FAIL b2b_second: req=%b lhs=%h, required 100/00000033", fu_req, fu_lhs);
    end
    fu_result = '0;
    fu_result[2*RW +: RW] = 33'h0_0000_0077;
    fu_valid = 3'b100;
    @(posedge clk); #1;
    fu_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    issue(2'd1, 2'd0, 32'h77, 32'h88, 5'd6, 1'b0);
    @(posedge clk); #1;  // 2nd EXEC cycle
    @(posedge clk); #1;  // 3rd EXEC cycle
    checks++;
    if (fu_req !== 3'b010) begin
      errors++;
      $display("FAIL rstmid_exec: req=%b, required 010", fu_req);
    end
    resetn = 1'b0;
    fu_result = '0;
    fu_result[1*RW +: RW] = 33'h1_0000_0055;
    fu_valid = 3'b010;
    @(posedge clk); #1;
    resetn = 1'b1;
    fu_valid = '0;
    checks++;
    if (i_ready !== 1'b1 || fu_req !== '0 || o_done !== 1'b0 || o_error !== 1'b0 ||
        d_rd_wen !== 1'b0 || d_pc_wen !== 1'b0 || d_rd_wdata !== '0 || o_carry !== 1'b0 ||
        fu_lhs !== '0) begin
      errors++;
      $display("FAIL rstmid_idle: ready=%0b req=%b done=%0b err=%0b rdw=%0b pcw=%0b rdd=%h carry=%0b lhs=%h, required 1/000/0/0/0/0/0/0/0",
               i_ready, fu_req, o_done, o_error, d_rd_wen, d_pc_wen, d_rd_wdata, o_carry, fu_lhs);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_timeout();
    test_delayed();
    test_illegal();
    test_x0();
    test_pc_update();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d completions outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
